bw_multiplier_seq: RTL and testbench
====================================

Name: bw_multiplier_seq

Overview:
Parametrised sequential Baugh-Wooley multiplier, the successor to the combinational bw_multiplier_s. It adds a per-operation signed/unsigned mode, valid/ready handshakes on input and output, and an iterative datapath that accumulates one partial-product row per clock. It sits in the arithmetic datapath wherever an area-cheap, multi-cycle 2*numBit-bit product is acceptable.

Parameters:
numBit, 4, operand width in bits; numBit >= 2; product width is 2*numBit.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid_in  input  1  operands and mode are valid this cycle.
in_ready_out  output  1  block can accept an operation; high only in IDLE.
m_in  input  numBit  multiplicand.
n_in  input  numBit  multiplier.
signed_in  input  1  1 = two's-complement operands (Baugh-Wooley); 0 = unsigned.
o_out  output  2*numBit  product; valid while out_valid_out = 1.
out_valid_out  output  1  result available.
out_ready_in  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous and active-high. On any edge with rst=1: state<=IDLE, o_out<=0, out_valid_out<=0, accumulator and row counter<=0. rst overrides every other input, including mid-RUN and mid-DONE; any operation in flight is discarded.
- in_ready_out = (state==IDLE), combinational from state, so it reads 1 in the first cycle after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - Acceptance: in_valid_in=1 at an edge while in IDLE.
  - On acceptance, capture m_in, n_in, signed_in; set row counter i<=0 and go to RUN.
  - Accumulator initial value: signed: 2^numBit + 2^(2*numBit-1), i.e. the Baugh-Wooley correction constant, modulo 2^(2*numBit). Unsigned: 0.
- RUN, one row per edge:
  - Row i has bit j = m[j] & n[i], weighted 2^(i+j).
  - Signed mode inverts that bit when exactly one of (i==numBit-1), (j==numBit-1) holds. The MSB*MSB bit is not inverted.
  - acc <= (acc + row_i) mod 2^(2*numBit); i <= i+1.
  - After row numBit-1 is added: o_out <= final acc, out_valid_out <= 1, state <= DONE.
- Latency: out_valid_out rises exactly numBit edges after the acceptance edge.
- DONE:
  - o_out and out_valid_out are held stable while out_ready_in=0 (backpressure).
  - On an edge with out_ready_in=1: out_valid_out<=0, state<=IDLE. o_out keeps its last value.
  - A new operation can be accepted no earlier than the following edge, so throughput is 1 operation per numBit+2 cycles minimum.
- in_valid_in is ignored outside IDLE; operand changes during RUN/DONE do not affect the result.
- o_out changes only on the RUN->DONE transition and on reset.
- Arithmetic is exact: signed result = sign-extended m * sign-extended n in 2*numBit bits; unsigned result = m*n. No overflow is possible.

Test Plan:
- numBit=4, signed_in=1, m=0101 (5), n=1010 (-6) -> after 4 edges out_valid=1, o_out=8'hE2 (-30); same operands with signed_in=0 -> o_out=8'h32 (50).
- numBit=4, m=1111, n=1111: signed -> 8'h01; unsigned -> 8'hE1. Also m=0000, n=0001 (either mode) -> 8'h00; m=1000, n=1000 signed -> 8'h40.
- Backpressure: hold out_ready_in=0 for 3 cycles after out_valid -> o_out stable, in_ready_out=0, an in_valid_in pulse (m=0011, n=0110) is ignored. Then out_ready_in=1 -> next cycle in_ready_out=1 and out_valid_out=0.
- Reset mid-operation: assert rst 2 cycles into RUN -> next cycle out_valid_out=0, o_out=0, in_ready_out=1. Then m=0011, n=0110 signed -> o_out=8'h12 exactly 4 edges after acceptance.
- Back-to-back: two operations issued as soon as in_ready_out allows -> each result correct, no cross-contamination of accumulator or mode.
- numBit=8, signed, m=8'h80 (-128), n=8'h7F (127) -> o_out=16'hC080 after 8 edges; unsigned same operands -> 16'h3F80.

Source files
------------

// File: rtl/bw_multiplier_seq.sv
// -----------------------------------------------------------------------------
// bw_multiplier_seq
//
// Iterative Baugh-Wooley multiplier. It accumulates one partial-product row per
// clock into a 2*numBit accumulator. It supports a per-operation signed or
// unsigned mode.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds its data stable while valid=1 and ready=0.
// The input side is ready only in IDLE. The output side holds o_out and
// out_valid_out stable until the consumer raises out_ready_in.
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   rst           - synchronous active-high reset
//   in_valid_in   - m_in/n_in/signed_in valid this cycle
//   in_ready_out  - block can accept an operation (IDLE only)
//   m_in, n_in    - multiplicand / multiplier, numBit bits each
//   signed_in     - 1 = two's-complement operands, 0 = unsigned
//   o_out         - 2*numBit-bit product, valid while out_valid_out = 1
//   out_valid_out - result available
//   out_ready_in  - consumer accepts the result
// -----------------------------------------------------------------------------
module bw_multiplier_seq #(
    parameter int numBit = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [numBit-1:0]     m_in,
    input  logic [numBit-1:0]     n_in,
    input  logic                  signed_in,
    output logic [2*numBit-1:0]   o_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in
);

    localparam int PW = 2 * numBit;
    localparam int CW = (numBit > 1) ? $clog2(numBit) : 1;

    // Baugh-Wooley correction constant: 2^numBit + 2^(2*numBit-1).
    localparam logic [PW-1:0] BW_INIT = (PW'(1) << numBit) | (PW'(1) << (PW - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [numBit-1:0]   r_m;
    logic [numBit-1:0]   r_n;
    logic                r_signed;
    logic [PW-1:0]       r_acc;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_out;
    logic                r_valid;

    logic                w_last;
    logic [numBit-1:0]   w_row_bits;
    logic [PW-1:0]       w_row;
    logic [PW-1:0]       w_sum;

    assign in_ready_out  = (r_state == IDLE);
    assign o_out         = r_out;
    assign out_valid_out = r_valid;

    assign w_last = (r_cnt == CW'(numBit - 1));

    // Row i = m & n[i]. In signed mode, a bit is inverted when exactly one of
    // its two source bits is a sign bit. The MSB*MSB term keeps its polarity.
    always_comb begin
        w_row_bits = '0;
        for (int j = 0; j < numBit; j++) begin
            w_row_bits[j] = (r_m[j] & r_n[r_cnt])
                          ^ (r_signed & (w_last ^ (j == numBit - 1)));
        end
    end

    assign w_row = {{numBit{1'b0}}, w_row_bits} << r_cnt;
    assign w_sum = r_acc + w_row;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid_in)  w_next = RUN;
            RUN:     if (w_last)       w_next = DONE;
            DONE:    if (out_ready_in) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m      <= '0;
            r_n      <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_in) begin
                        r_m      <= m_in;
                        r_n      <= n_in;
                        r_signed <= signed_in;
                        r_cnt    <= '0;
                        r_acc    <= signed_in ? BW_INIT : '0;
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out   <= w_sum;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_in) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_multiplier_seq.sv
module tb_bw_multiplier_seq;

  logic clk;
  logic rst;

  // numBit = 4 instance
  logic       in_valid4, in_ready4, signed4, out_valid4, out_ready4;
  logic [3:0] m4, n4;
  logic [7:0] o4;

  // numBit = 8 instance
  logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8;
  logic [7:0]  m8, n8;
  logic [15:0] o8;

  int tests;
  int fails;

  typedef struct {
    logic [3:0] m;
    logic [3:0] n;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  bw_multiplier_seq #(.numBit(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid_in(in_valid4), .in_ready_out(in_ready4),
    .m_in(m4), .n_in(n4), .signed_in(signed4),
    .o_out(o4), .out_valid_out(out_valid4), .out_ready_in(out_ready4)
  );

  bw_multiplier_seq #(.numBit(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid_in(in_valid8), .in_ready_out(in_ready8),
    .m_in(m8), .n_in(n8), .signed_in(signed8),
    .o_out(o8), .out_valid_out(out_valid8), .out_ready_in(out_ready8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Issues one op to dut4, returns result and the number
  // of rising edges from acceptance to out_valid. Leaves out_ready low, so the
  // caller decides when the result is consumed.
  task automatic issue4(input logic [3:0] m, input logic [3:0] n, input logic s,
                        output logic [7:0] res, output int lat);
    int k;
    k = 0;
    while (!in_ready4 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) check("ready4_timeout", 16'(in_ready4), 16'd1);
    in_valid4 = 1'b1;
    m4 = m; n4 = n; signed4 = s;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    m4 = 4'hA; n4 = 4'h5; signed4 = ~s;   // garbage: must not affect result
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid4 && lat < 20);
    res = o4;
  endtask

  task automatic release4();
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] m, input logic [7:0] n, input logic s,
                        output logic [15:0] res, output int lat);
    in_valid8 = 1'b1;
    m8 = m; n8 = n; signed8 = s;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid8 && lat < 30);
    res = o8;
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  logic [7:0]  r4;
  logic [15:0] r8;
  int          lat;

  initial begin
    tests = 0;
    fails = 0;

    vecs[0]  = '{4'b0101, 4'b1010, 1'b1, 8'hE2};  // 5 * -6 = -30
    vecs[1]  = '{4'b0101, 4'b1010, 1'b0, 8'h32};  // 5 * 10 = 50
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 8'h01};  // -1 * -1
    vecs[3]  = '{4'b1111, 4'b1111, 1'b0, 8'hE1};  // 15 * 15 = 225
    vecs[4]  = '{4'b0000, 4'b0001, 1'b1, 8'h00};
    vecs[5]  = '{4'b0000, 4'b0001, 1'b0, 8'h00};
    vecs[6]  = '{4'b1000, 4'b1000, 1'b1, 8'h40};  // -8 * -8 = 64
    vecs[7]  = '{4'b1000, 4'b1000, 1'b0, 8'h40};  // 8 * 8 = 64
    vecs[8]  = '{4'b0111, 4'b1000, 1'b1, 8'hC8};  // 7 * -8 = -56
    vecs[9]  = '{4'b0111, 4'b1000, 1'b0, 8'h38};  // 7 * 8 = 56
    vecs[10] = '{4'b1111, 4'b0111, 1'b1, 8'hF9};  // -1 * 7 = -7
    vecs[11] = '{4'b0011, 4'b0110, 1'b1, 8'h12};  // 3 * 6 = 18

    rst = 1'b1;
    in_valid4 = 1'b0; m4 = '0; n4 = '0; signed4 = 1'b0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; m8 = '0; n8 = '0; signed8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_o_out",  16'(o4), 16'h0);
    check("rst_valid",  16'(out_valid4), 16'h0);
    check("rst_ready",  16'(in_ready4), 16'h1);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      issue4(vecs[i].m, vecs[i].n, vecs[i].s, r4, lat);
      check($sformatf("vec%0d_result", i), 16'(r4), 16'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'd4);
      release4();
      check($sformatf("vec%0d_idle_ready", i), 16'(in_ready4), 16'h1);
      check($sformatf("vec%0d_idle_valid", i), 16'(out_valid4), 16'h0);
      check($sformatf("vec%0d_hold_o", i), 16'(o4), 16'(vecs[i].exp));
    end

    // backpressure: hold result 3 cycles, ignored in_valid pulse
    issue4(4'b0101, 4'b1010, 1'b1, r4, lat);
    check("bp_result", 16'(r4), 16'hE2);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        in_valid4 = 1'b1; m4 = 4'b0011; n4 = 4'b0110; signed4 = 1'b1;
      end else begin
        in_valid4 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_o_c%0d", c), 16'(o4), 16'hE2);
      check($sformatf("bp_valid_c%0d", c), 16'(out_valid4), 16'h1);
      check($sformatf("bp_ready_c%0d", c), 16'(in_ready4), 16'h0);
    end
    in_valid4 = 1'b0;
    release4();
    check("bp_after_ready", 16'(in_ready4), 16'h1);
    check("bp_after_valid", 16'(out_valid4), 16'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_pulse_ignored_valid", 16'(out_valid4), 16'h0);
    check("bp_pulse_ignored_ready", 16'(in_ready4), 16'h1);

    // reset mid-operation: 2 rows into RUN
    in_valid4 = 1'b1; m4 = 4'b1111; n4 = 4'b1111; signed4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 16'(out_valid4), 16'h0);
    check("midrst_o_out", 16'(o4), 16'h0);
    check("midrst_ready", 16'(in_ready4), 16'h1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midrst_no_late_valid", 16'(out_valid4), 16'h0);
    issue4(4'b0011, 4'b0110, 1'b1, r4, lat);
    check("midrst_next_result", 16'(r4), 16'h12);
    check("midrst_next_latency", 16'(lat), 16'd4);
    release4();

    // back-to-back: second op issued the cycle ready returns, mode flips
    issue4(4'b1111, 4'b1111, 1'b1, r4, lat);
    check("b2b_a_result", 16'(r4), 16'h01);
    release4();
    issue4(4'b1111, 4'b1111, 1'b0, r4, lat);
    check("b2b_b_result", 16'(r4), 16'hE1);
    check("b2b_b_latency", 16'(lat), 16'd4);
    release4();
    issue4(4'b0101, 4'b1010, 1'b1, r4, lat);
    check("b2b_c_result", 16'(r4), 16'hE2);
    release4();

    // numBit = 8
    issue8(8'h80, 8'h7F, 1'b1, r8, lat);
    check("w8_signed_result", r8, 16'hC080);
    check("w8_signed_latency", 16'(lat), 16'd8);
    issue8(8'h80, 8'h7F, 1'b0, r8, lat);
    check("w8_unsigned_result", r8, 16'h3F80);
    check("w8_unsigned_latency", 16'(lat), 16'd8);
    issue8(8'hFF, 8'h02, 1'b1, r8, lat);
    check("w8_neg1x2", r8, 16'hFFFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
